// File: rtl/uart_frame_sender.sv
// Framed UART transmitter: on a FIFO burst edge, sends HDR0, HDR1, a runtime-length
// payload pulled from the FIFO, then an optional 8-bit additive checksum.
module uart_frame_sender #(
    parameter int         CLK_FREQ  = 200000000,
    parameter int         UART_BPS  = 115200,
    parameter int         STOP_BITS = 1,
    parameter int         LEN_W     = 10,
    parameter logic [7:0] HDR0      = 8'hA5,
    parameter logic [7:0] HDR1      = 8'h5A,
    parameter int         CSUM_EN   = 1,
    parameter int         TRIG_EDGE = 0
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic             in_fifo_sig,
    input  logic [LEN_W-1:0] in_frame_len,
    input  logic [7:0]       in_uart_data,
    output logic             out_fifo_rd_en,
    output logic             out_uart_txd,
    output logic             out_busy,
    output logic             out_frame_done,
    output logic [LEN_W-1:0] out_byte_cnt
);
    localparam int DIV_RAW  = CLK_FREQ / UART_BPS;
    localparam int BAUD_DIV = (DIV_RAW < 2) ? 2 : DIV_RAW;
    localparam int NBITS    = 9 + STOP_BITS;
    localparam int BW       = $clog2(BAUD_DIV);
    localparam int IW       = $clog2(NBITS);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR0, S_HDR1, S_P_RD, S_P_CAP, S_P_TX, S_CSUM, S_DONE
    } state_t;

    localparam state_t S_AFTER_PAY = (CSUM_EN != 0) ? S_CSUM : S_DONE;

    state_t           r_state, w_next;
    logic             r_sig_d;
    logic [LEN_W-1:0] r_len, r_cnt;
    logic [7:0]       r_csum;
    logic             r_issued;
    logic             r_tx_act;
    logic [NBITS-1:0] r_shift;
    logic [BW-1:0]    r_baud;
    logic [IW-1:0]    r_bit;

    logic             w_trig, w_load, w_baud_end, w_tx_done;
    logic [7:0]       w_load_byte;

    assign w_trig     = (TRIG_EDGE != 0) ? (in_fifo_sig & ~r_sig_d) : (~in_fifo_sig & r_sig_d);
    assign w_baud_end = r_tx_act && (r_baud == BW'(BAUD_DIV - 1));
    assign w_tx_done  = w_baud_end && (r_bit == IW'(NBITS - 1));

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_load      = 1'b0;
        w_load_byte = 8'h00;
        case (r_state)
            S_IDLE:  if (w_trig) w_next = S_HDR0;
            S_HDR0: begin
                w_load      = !r_issued;
                w_load_byte = HDR0;
                if (w_tx_done) w_next = S_HDR1;
            end
            S_HDR1: begin
                w_load      = !r_issued;
                w_load_byte = HDR1;
                if (w_tx_done) w_next = (r_len == '0) ? S_AFTER_PAY : S_P_RD;
            end
            S_P_RD:  w_next = S_P_CAP;
            S_P_CAP: begin
                w_load      = 1'b1;
                w_load_byte = in_uart_data;
                w_next      = S_P_TX;
            end
            S_P_TX:  if (w_tx_done) w_next = (r_cnt == r_len) ? S_AFTER_PAY : S_P_RD;
            S_CSUM: begin
                w_load      = !r_issued;
                w_load_byte = r_csum;
                if (w_tx_done) w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // r_issued makes the single-byte states load exactly once, on their first cycle
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            r_sig_d  <= 1'b0;
            r_len    <= '0;
            r_cnt    <= '0;
            r_csum   <= 8'h00;
            r_issued <= 1'b0;
        end else begin
            r_sig_d  <= in_fifo_sig;
            r_issued <= (w_next == r_state) && (r_issued || w_load);
            if (r_state == S_IDLE && w_trig) begin
                r_len  <= in_frame_len;
                r_cnt  <= '0;
                r_csum <= 8'h00;
            end else if (r_state == S_P_CAP) begin
                r_cnt  <= r_cnt + 1'b1;
                r_csum <= r_csum + in_uart_data;
            end
        end
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            r_tx_act <= 1'b0;
            r_shift  <= '1;
            r_baud   <= '0;
            r_bit    <= '0;
        end else if (w_load) begin
            r_tx_act <= 1'b1;
            r_shift  <= {{STOP_BITS{1'b1}}, w_load_byte, 1'b0};
            r_baud   <= '0;
            r_bit    <= '0;
        end else if (r_tx_act) begin
            if (w_baud_end) begin
                r_baud  <= '0;
                r_shift <= {1'b1, r_shift[NBITS-1:1]};
                r_bit   <= r_bit + 1'b1;
                if (w_tx_done) r_tx_act <= 1'b0;
            end else begin
                r_baud <= r_baud + 1'b1;
            end
        end
    end

    assign out_fifo_rd_en = (r_state == S_P_RD);
    assign out_busy       = (r_state != S_IDLE) && (r_state != S_DONE);
    assign out_frame_done = (r_state == S_DONE);
    assign out_uart_txd   = r_tx_act ? r_shift[0] : 1'b1;
    assign out_byte_cnt   = r_cnt;
endmodule

// File: tb/tb_uart_frame_sender.sv
// Bench for uart_frame_sender: two instances (default-style and CSUM_EN=0/2 stop/rising
// trigger), a UART line decoder, and a byte-list/timing model of each frame.
module tb_uart_frame_sender;
    localparam int LEN_W = 10;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             sig    [2];
    logic [LEN_W-1:0] len_in [2];
    logic [7:0]       dat    [2];
    logic             rd     [2];
    logic             txd    [2];
    logic             busy   [2];
    logic             done   [2];
    logic [LEN_W-1:0] bcnt   [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : u
        uart_frame_sender #(
            .CLK_FREQ(1000), .UART_BPS(100), .STOP_BITS(g + 1), .LEN_W(LEN_W),
            .HDR0(8'hA5), .HDR1(8'h5A), .CSUM_EN(1 - g), .TRIG_EDGE(g)
        ) dut (
            .in_clk(clk), .in_rst(rst_n), .in_fifo_sig(sig[g]), .in_frame_len(len_in[g]),
            .in_uart_data(dat[g]), .out_fifo_rd_en(rd[g]), .out_uart_txd(txd[g]),
            .out_busy(busy[g]), .out_frame_done(done[g]), .out_byte_cnt(bcnt[g])
        );
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // line monitor / FIFO model; all counters are monotonic, the tasks diff them
    int         rx_act [2] = '{0, 0};
    int         rx_s   [2];
    int         rx_n   [2] = '{0, 0};
    logic [7:0] rx_sh  [2];
    logic [7:0] rx_byte [2][256];
    int         rx_start[2][256];
    int         rd_cnt [2] = '{0, 0};
    int         rd_ptr [2] = '{0, 0};
    int         done_cnt [2] = '{0, 0};
    int         done_cyc [2];
    int         busy_cnt [2] = '{0, 0};
    int         busy_rise[2];
    logic       busy_prev[2] = '{1'b0, 1'b0};
    int         stop_bad [2] = '{0, 0};
    logic [7:0] fifo [2][256];

    always @(negedge clk) begin
        int k;
        for (int g = 0; g < 2; g++) begin
            if (rd[g]) begin
                rd_cnt[g]++;
                dat[g] = fifo[g][rd_ptr[g] % 256];
                rd_ptr[g]++;
            end
            if (done[g]) begin
                done_cnt[g]++;
                done_cyc[g] = cyc;
            end
            if (busy[g]) busy_cnt[g]++;
            if (busy[g] && !busy_prev[g]) busy_rise[g] = cyc;
            busy_prev[g] = busy[g];
            if (!rst_n) rx_act[g] = 0;
            else if (rx_act[g] == 0) begin
                if (!txd[g]) begin
                    rx_act[g] = 1;
                    rx_s[g] = cyc;
                end
            end else begin
                k = cyc - rx_s[g];
                if (k % 10 == 5) begin
                    if (k / 10 == 0 && txd[g]) stop_bad[g]++;
                    else if (k / 10 >= 1 && k / 10 <= 8) rx_sh[g][k/10-1] = txd[g];
                    else if (k / 10 > 8 && !txd[g]) stop_bad[g]++;
                end
                if (k == 10 * (10 + g) - 1) begin
                    rx_byte[g][rx_n[g] % 256]  = rx_sh[g];
                    rx_start[g][rx_n[g] % 256] = rx_s[g];
                    rx_n[g]++;
                    rx_act[g] = 0;
                end
            end
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    logic [7:0] pl[16];

    // Expected frame: header, payload, optional checksum; each start bit follows the
    // previous byte's end by 2 cycles before a payload byte, 1 cycle otherwise.
    task automatic run_frame(input int g, input int len, input bit retrig);
        logic [7:0] eb[20];
        int es[20];
        int nb, n0, sum, d, ed, t, b_rx, b_rd, b_dn, b_bz, b_sb;
        d = 10 * (10 + g);
        b_rx = rx_n[g]; b_rd = rd_cnt[g]; b_dn = done_cnt[g]; b_bz = busy_cnt[g]; b_sb = stop_bad[g];
        for (int i = 0; i < len; i++) fifo[g][(rd_ptr[g] + i) % 256] = pl[i];
        eb[0] = 8'hA5; eb[1] = 8'h5A; nb = 2; sum = 0;
        for (int i = 0; i < len; i++) begin
            eb[nb] = pl[i]; nb++; sum += pl[i];
        end
        if (g == 0) begin eb[nb] = 8'(sum); nb++; end
        len_in[g] = LEN_W'(len);
        tick();
        n0 = cyc;
        sig[g] = (g == 0) ? 1'b0 : 1'b1;
        es[0] = n0 + 2;
        for (int i = 1; i < nb; i++) es[i] = es[i-1] + d + ((i >= 2 && i < 2 + len) ? 2 : 1);
        ed = es[nb-1] + d;
        tick();
        chk("busy_after_trig", busy[g], 1);
        chk("byte_cnt_restart", bcnt[g], 0);
        if (retrig) begin
            for (t = 0; t < 2000 && rx_n[g] - b_rx < 3; t++) tick();
            chk("retrig_reach_payload", int'(rx_n[g] - b_rx >= 3), 1);
            repeat (20) tick();
            sig[g] = ~sig[g];
            tick();
            sig[g] = ~sig[g];
        end
        for (t = 0; t < 4000 && done_cnt[g] == b_dn; t++) tick();
        repeat (300) tick();
        chk("done_pulses", done_cnt[g] - b_dn, 1);
        chk("done_cycle", done_cyc[g], ed);
        chk("bytes_rx", rx_n[g] - b_rx, nb);
        for (int i = 0; i < nb; i++) begin
            chk($sformatf("g%0d_byte%0d", g, i), rx_byte[g][(b_rx + i) % 256], eb[i]);
            chk($sformatf("g%0d_start%0d", g, i), rx_start[g][(b_rx + i) % 256], es[i]);
        end
        chk("rd_pulses", rd_cnt[g] - b_rd, len);
        chk("byte_cnt_end", bcnt[g], len);
        chk("busy_rise", busy_rise[g], n0 + 1);
        chk("busy_cycles", busy_cnt[g] - b_bz, ed - n0 - 1);
        chk("framing", stop_bad[g] - b_sb, 0);
        chk("txd_idle", txd[g], 1);
        b_bz = busy_cnt[g];
        b_rx = rx_n[g];
        sig[g] = (g == 0) ? 1'b1 : 1'b0;
        repeat (60) tick();
        chk("wrong_edge_no_frame", (busy_cnt[g] - b_bz) + (rx_n[g] - b_rx), 0);
    endtask

    task automatic reset_mid();
        int t, b_rx, b_dn;
        b_rx = rx_n[0]; b_dn = done_cnt[0];
        for (int i = 0; i < 4; i++) fifo[0][(rd_ptr[0] + i) % 256] = 8'($urandom);
        len_in[0] = LEN_W'(4);
        tick();
        sig[0] = 1'b0;
        for (t = 0; t < 3000 && !(rx_n[0] - b_rx >= 3 && rx_act[0] != 0); t++) tick();
        chk("rst_reach_byte2", int'(rx_n[0] - b_rx >= 3 && rx_act[0] != 0), 1);
        repeat (25) tick();
        rst_n = 1'b0;
        #1;
        chk("rst_async_txd", txd[0], 1);
        chk("rst_async_busy", busy[0], 0);
        chk("rst_async_rd", rd[0], 0);
        chk("rst_async_cnt", bcnt[0], 0);
        repeat (3) tick();
        chk("rst_no_done", done_cnt[0] - b_dn, 0);
        rst_n = 1'b1;
        sig[0] = 1'b1;
        repeat (40) tick();
        chk("rst_recover_idle", busy[0], 0);
        chk("rst_recover_txd", txd[0], 1);
    endtask

    initial begin
        sig[0] = 1'b1; sig[1] = 1'b0;
        len_in[0] = '0; len_in[1] = '0;
        repeat (3) tick();
        for (int g = 0; g < 2; g++) begin
            chk("reset_txd", txd[g], 1);
            chk("reset_rd", rd[g], 0);
            chk("reset_busy", busy[g], 0);
            chk("reset_done", done[g], 0);
            chk("reset_cnt", bcnt[g], 0);
        end
        rst_n = 1'b1;
        repeat (5) tick();
        chk("no_spurious_start", int'(busy[0] | busy[1]), 0);

        pl[0] = 8'h01; pl[1] = 8'h02; pl[2] = 8'hFF;
        run_frame(0, 3, 1'b0);
        run_frame(0, 0, 1'b0);
        for (int i = 0; i < 3; i++) pl[i] = 8'($urandom);
        run_frame(0, 3, 1'b1);
        for (int i = 0; i < 2; i++) pl[i] = 8'($urandom);
        run_frame(0, 2, 1'b0);
        reset_mid();
        for (int i = 0; i < 2; i++) pl[i] = 8'($urandom);
        run_frame(1, 2, 1'b0);
        for (int i = 0; i < 4; i++) pl[i] = 8'h80;
        run_frame(0, 4, 1'b0);
        for (int r = 0; r < 4; r++) begin
            int g, len;
            g = int'($urandom_range(0, 1));
            len = int'($urandom_range(0, 6));
            for (int i = 0; i < len; i++) pl[i] = 8'($urandom);
            run_frame(g, len, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_frame_sender.md
Name: uart_frame_sender

Overview:
- Parametrised successor to the single-burst UART send controller, with its own bit serializer, header bytes and checksum.
- Waits for the end of a FIFO burst, then sends one framed packet: header bytes, a payload of runtime length pulled byte-by-byte from the upstream FIFO, then an optional 8-bit checksum.
- Sits between the capture FIFO and the board TXD pin; exports busy/done/count status to the control logic.

Parameters:
- CLK_FREQ, 200000000, system clock frequency in Hz.
- UART_BPS, 115200, baud rate. BAUD_DIV = CLK_FREQ/UART_BPS (integer division), minimum 2.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.
- LEN_W, 10, width of the payload length and byte counter.
- HDR0, 8'hA5, first header byte.
- HDR1, 8'h5A, second header byte.
- CSUM_EN, 1, 1 = append checksum byte; 0 = no checksum byte.
- TRIG_EDGE, 0, 0 = trigger on falling edge of in_fifo_sig; 1 = trigger on rising edge.

Ports:
- in_clk, input, 1, system clock.
- in_rst, input, 1, reset; asynchronous, active-low.
- in_fifo_sig, input, 1, FIFO burst-active level; the selected edge starts a frame.
- in_frame_len, input, LEN_W, payload byte count; sampled on the trigger cycle.
- in_uart_data, input, 8, FIFO read data; valid the cycle after out_fifo_rd_en.
- out_fifo_rd_en, output, 1, one-cycle read strobe to the FIFO.
- out_uart_txd, output, 1, serial line; idles high.
- out_busy, output, 1, high while a frame is in progress.
- out_frame_done, output, 1, one-cycle pulse at the end of a frame.
- out_byte_cnt, output, LEN_W, payload bytes sent so far in the current frame.

Behaviour:
- Reset (in_rst=0, asynchronous): txd=1, rd_en=0, busy=0, frame_done=0, byte_cnt=0, FSM=IDLE, edge-detect register=0. Reset mid-frame aborts the frame immediately, with no frame_done pulse.
- Trigger:
  - Edge detect uses a registered copy of in_fifo_sig. TRIG_EDGE=0 fires on (sig==0 && sig_d==1); TRIG_EDGE=1 fires on (sig==1 && sig_d==0).
  - On a trigger seen in IDLE: latch in_frame_len, clear the checksum and byte_cnt, go to HDR0. busy=1 from the next cycle.
  - Triggers while busy are ignored and are not queued.
- FSM states and transitions:
  - IDLE -> HDR0 -> HDR1 -> PAYLOAD -> CSUM -> DONE -> IDLE.
  - PAYLOAD is skipped when the latched length is 0.
  - CSUM is skipped when CSUM_EN=0.
- Serializer:
  - Frame is 1 start bit (0), 8 data bits LSB first, STOP_BITS stop bits (1). Each bit lasts BAUD_DIV cycles.
  - It pulses tx_done internally on the last cycle of the final stop bit.
  - Loading a byte drives the start bit on the cycle after the load.
- HDR0/HDR1/CSUM: load the constant or checksum on the first cycle of the state; advance on tx_done. The idle gap after tx_done is 1 cycle before the next start bit.
- PAYLOAD, per byte:
  - Cycle after entry (or after tx_done): rd_en=1 for exactly 1 cycle.
  - Next cycle: capture in_uart_data, load the serializer, add the byte to the checksum (mod 256), increment byte_cnt.
  - The idle gap between payload bytes is 2 cycles.
  - When byte_cnt equals the latched length and tx_done fires, go to CSUM (or DONE).
- DONE: lasts one cycle. frame_done=1 and busy=0 on that same cycle. byte_cnt holds its value until the next trigger.
- Checksum = 8-bit wrap-around sum of payload bytes only; headers are excluded. With length 0 the checksum is 8'h00.
- rd_en is never asserted outside PAYLOAD. Exactly latched-length strobes occur per frame.
- txd is 1 at all times when no byte is being shifted.

Test Plan:
All scenarios use CLK_FREQ=1000 and UART_BPS=100 (BAUD_DIV=10) unless noted.
- Basic frame:
  - Stimulus: in_frame_len=3, FIFO returns 8'h01, 8'h02, 8'hFF; in_fifo_sig 1->0.
  - Required response: txd decodes A5 5A 01 02 FF 02. Exactly 3 rd_en pulses. byte_cnt ends at 3. One frame_done pulse. busy high from trigger+1 to the done cycle.
- Zero length:
  - Stimulus: in_frame_len=0.
  - Required response: txd sends A5 5A 00. No rd_en pulses. frame_done=1.
- Retrigger while busy:
  - Stimulus: a second falling edge mid-payload.
  - Required response: the frame is unchanged and no second frame follows.
  - Follow-up: a trigger after done starts a new frame and byte_cnt restarts at 0.
- Reset mid-frame:
  - Stimulus: drop in_rst during the 2nd payload byte.
  - Required response: txd=1 and busy=0 within the same cycle (asynchronous). No frame_done pulse.
- Parameter variants:
  - Stimulus: CSUM_EN=0, STOP_BITS=2, TRIG_EDGE=1, length 2, rising-edge trigger.
  - Required response: txd sends A5 5A d0 d1. Each byte is 11 bit times (110 cycles).
  - Also check: a falling edge of in_fifo_sig produces no frame.
- Checksum wrap:
  - Stimulus: 4 payload bytes of 8'h80.
  - Required response: checksum byte 8'h00.
  - Also check: the 2-cycle gap between payload bytes is measured exactly.
